// File: rtl/snn_pe_sync.sv
// snn_pe_sync: clocked spiking-convolution PE producing channel-major 1-D valid convolutions added to a chained psum.
// Optional macro SNN_PE_PSUM_SAT_EN: saturating MAC additions instead of two's-complement wrap-around.
//
// state     | meaning
// S_IDLE    | frames may be loaded, waiting for start
// S_LOAD    | waiting for the incoming psum of the current (c,p)
// S_MAC     | one weight*spike term accumulated per cycle
// S_EMIT    | result offered downstream, held until accepted
// S_DONE    | one-cycle end-of-pass pulse
module snn_pe_sync #(
  parameter int FILTER_WIDTH = 8,
  parameter int DEPTH_F      = 3,
  parameter int DEPTH_I      = 5,
  parameter int NUM_CH       = 2,
  parameter int PSUM_WIDTH   = 16
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_CH*DEPTH_F*FILTER_WIDTH-1:0]    filter_data,
  input  logic                                      filter_valid,
  output logic                                      filter_ready,
  input  logic [DEPTH_I-1:0]                        ifmap_data,
  input  logic                                      ifmap_valid,
  output logic                                      ifmap_ready,
  output logic [NUM_CH*DEPTH_F*FILTER_WIDTH-1:0]    filter_fwd_data,
  output logic                                      filter_fwd_valid,
  output logic [DEPTH_I-1:0]                        ifmap_fwd_data,
  output logic                                      ifmap_fwd_valid,
  input  logic                                      start,
  input  logic signed [PSUM_WIDTH-1:0]              psum_in_data,
  input  logic                                      psum_in_valid,
  output logic                                      psum_in_ready,
  output logic signed [PSUM_WIDTH-1:0]              psum_out_data,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] psum_out_ch,
  output logic                                      psum_out_valid,
  input  logic                                      psum_out_ready,
  output logic                                      busy,
  output logic                                      done
);
  localparam int NUM_W   = NUM_CH * DEPTH_F;
  localparam int FRAME_W = NUM_W * FILTER_WIDTH;
  localparam int NUM_OUT = DEPTH_I - DEPTH_F + 1;
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int P_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int K_W     = (DEPTH_F > 1) ? $clog2(DEPTH_F) : 1;
  localparam int WI_W    = (NUM_W > 1) ? $clog2(NUM_W) : 1;
  localparam int SI_W    = (DEPTH_I > 1) ? $clog2(DEPTH_I) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_EMIT, S_DONE} state_t;

  state_t state, state_nxt;

  logic [FRAME_W-1:0]                filt_mem;
  logic [DEPTH_I-1:0]                ifmap_mem;
  logic signed [PSUM_WIDTH-1:0]      acc;
  logic [CH_W-1:0]                   ch;
  logic [P_W-1:0]                    pos;
  logic [K_W-1:0]                    k;

  logic signed [FILTER_WIDTH-1:0]    w_arr [NUM_W];
  logic [WI_W-1:0]                   widx;
  logic [SI_W-1:0]                   sidx;
  logic signed [FILTER_WIDTH-1:0]    w_sel;
  logic signed [PSUM_WIDTH-1:0]      addend;
  logic signed [PSUM_WIDTH-1:0]      mac_sum;
  logic                              k_last, p_last, c_last;
  logic                              filter_xfer, ifmap_xfer;

  for (genvar i = 0; i < NUM_W; i++) begin : g_w
    assign w_arr[i] = filt_mem[i*FILTER_WIDTH +: FILTER_WIDTH];
  end

  assign k_last      = (k == K_W'(DEPTH_F - 1));
  assign p_last      = (pos == P_W'(NUM_OUT - 1));
  assign c_last      = (ch == CH_W'(NUM_CH - 1));
  assign filter_xfer = filter_valid && filter_ready;
  assign ifmap_xfer  = ifmap_valid && ifmap_ready;

  always_comb begin
    widx   = WI_W'(ch) * WI_W'(DEPTH_F) + WI_W'(k);
    sidx   = SI_W'(pos) + SI_W'(k);
    w_sel  = w_arr[widx];
    addend = ifmap_mem[sidx] ? {{(PSUM_WIDTH-FILTER_WIDTH){w_sel[FILTER_WIDTH-1]}}, w_sel}
                             : '0;
  end

`ifdef SNN_PE_PSUM_SAT_EN
  logic signed [PSUM_WIDTH:0] sum_wide;
  always_comb begin
    sum_wide = {acc[PSUM_WIDTH-1], acc} + {addend[PSUM_WIDTH-1], addend};
    if (sum_wide[PSUM_WIDTH] != sum_wide[PSUM_WIDTH-1])
      mac_sum = sum_wide[PSUM_WIDTH] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}}
                                     : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
    else
      mac_sum = sum_wide[PSUM_WIDTH-1:0];
  end
`else
  assign mac_sum = acc + addend;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    filter_ready   = 1'b0;
    ifmap_ready    = 1'b0;
    psum_in_ready  = 1'b0;
    psum_out_valid = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    case (state)
      S_IDLE: begin
        filter_ready = 1'b1;
        ifmap_ready  = 1'b1;
        busy         = 1'b0;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        psum_in_ready = 1'b1;
        if (psum_in_valid) state_nxt = S_MAC;
      end
      S_MAC: begin
        if (k_last) state_nxt = S_EMIT;
      end
      S_EMIT: begin
        psum_out_valid = 1'b1;
        if (psum_out_ready) state_nxt = (p_last && c_last) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_mem         <= '0;
      ifmap_mem        <= '0;
      filter_fwd_data  <= '0;
      ifmap_fwd_data   <= '0;
      filter_fwd_valid <= 1'b0;
      ifmap_fwd_valid  <= 1'b0;
      acc              <= '0;
      ch               <= '0;
      pos              <= '0;
      k                <= '0;
    end else begin
      filter_fwd_valid <= filter_xfer;
      ifmap_fwd_valid  <= ifmap_xfer;
      if (filter_xfer) begin
        filt_mem        <= filter_data;
        filter_fwd_data <= filter_data;
      end
      if (ifmap_xfer) begin
        ifmap_mem      <= ifmap_data;
        ifmap_fwd_data <= ifmap_data;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            ch  <= '0;
            pos <= '0;
          end
        end
        S_LOAD: begin
          if (psum_in_valid) begin
            acc <= psum_in_data;
            k   <= '0;
          end
        end
        S_MAC: begin
          acc <= mac_sum;
          k   <= k_last ? '0 : k + 1'b1;
        end
        S_EMIT: begin
          // channel-major: position advances first, channel wraps to 0 after the last result
          if (psum_out_ready) begin
            if (p_last) begin
              pos <= '0;
              ch  <= c_last ? '0 : ch + 1'b1;
            end else begin
              pos <= pos + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign psum_out_data = acc;
  assign psum_out_ch   = ch;

endmodule
